// File: rtl/non_restoring_div_pkg.sv
// Shared types and constants for the non-restoring divider.
package non_restoring_div_pkg;

    // Controller states: idle/ready, one quotient bit per cycle, final correction.
    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFix
    } state_e;

    // Iteration counter width; the counter runs 0 .. width-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

    // Quotient reported on divide-by-zero (all ones, sliced to WIDTH at use).
    localparam logic [63:0] DivByZeroQuot = '1;

endpackage

// File: rtl/nr_div_step.sv
// One combinational non-restoring division step: shift in the next dividend bit,
// then subtract or add the divisor depending on the sign of the previous remainder.
module nr_div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH:0] p,
    input  logic [WIDTH:0] m,
    input  logic           dbit,
    output logic [WIDTH:0] p_next,
    output logic           q_bit
);

    logic [WIDTH:0] shifted;

    // Sign of the previous remainder picks subtract (>= 0) or add (< 0).
    always_comb begin
        shifted = {p[WIDTH-1:0], dbit};
        if (p[WIDTH]) begin
            p_next = shifted + m;
        end else begin
            p_next = shifted - m;
        end
        q_bit = ~p_next[WIDTH];
    end

endmodule

// File: rtl/non_restoring_divider.sv
// Multi-cycle non-restoring integer divider with start/done handshake,
// optional two's-complement mode, divide-by-zero and signed-overflow flags.
module non_restoring_divider
    import non_restoring_div_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned      CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] DbzQuot = DivByZeroQuot[WIDTH-1:0];

    state_e state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH:0]   m_q, m_d;
    // Holds the dividend bits still to be shifted out and the quotient bits shifted in.
    logic [WIDTH-1:0] q_q, q_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_out_q, dbz_out_d;
    logic             ovf_out_q, ovf_out_d;

    logic             sgn;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH:0]   step_p;
    logic             step_q;

    assign sgn = SIGNED_EN & is_signed;

    // A W-bit negate of the most-negative value yields 2^(W-1), exact as an unsigned magnitude.
    assign dvd_mag = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_mag = (sgn && divisor[WIDTH-1]) ? -divisor : divisor;

    // Final restore: a negative partial remainder gets M added back (result fits in W bits).
    assign rem_mag = p_q[WIDTH] ? (p_q[WIDTH-1:0] + m_q[WIDTH-1:0]) : p_q[WIDTH-1:0];

    nr_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p      (p_q),
        .m      (m_q),
        .dbit   (q_q[WIDTH-1]),
        .p_next (step_p),
        .q_bit  (step_q)
    );

    // Next-state and datapath updates for the accept / iterate / fix sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        m_d       = m_q;
        q_d       = q_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_out_d = dbz_out_q;
        ovf_out_d = ovf_out_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    neg_q_d = sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r_d = sgn & dividend[WIDTH-1];
                    ovf_d   = sgn && (dividend == MostNeg) && (divisor == '1);
                    p_d     = '0;
                    cnt_d   = '0;
                    if (divisor == '0) begin
                        // Keep the raw dividend so it can be returned as the remainder.
                        state_d = StFix;
                        dbz_d   = 1'b1;
                        q_d     = dividend;
                        m_d     = '0;
                    end else begin
                        state_d = StIter;
                        dbz_d   = 1'b0;
                        q_d     = dvd_mag;
                        m_d     = {1'b0, dvs_mag};
                    end
                end
            end
            StIter: begin
                p_d   = step_p;
                q_d   = {q_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (dbz_q) begin
                    quot_d    = DbzQuot;
                    rem_d     = q_q;
                    dbz_out_d = 1'b1;
                    ovf_out_d = 1'b0;
                end else begin
                    // Overflow needs no special case: magnitude 2^(W-1) wraps to most-negative.
                    quot_d    = neg_q_q ? -q_q : q_q;
                    rem_d     = neg_r_q ? -rem_mag : rem_mag;
                    dbz_out_d = 1'b0;
                    ovf_out_d = ovf_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; synchronous reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            p_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_out_q <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            m_q       <= m_d;
            q_q       <= q_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_out_q <= dbz_out_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign ready       = (state_q == StIdle);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_out_q;
    assign overflow    = ovf_out_q;

endmodule

// File: tb/tb_non_restoring_divider.sv
// Directed bench for non_restoring_divider: a 16-bit signed-capable instance and
// an 8-bit unsigned-only instance sharing clock and reset.
module tb_non_restoring_divider;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start16, sgn16;
    logic [15:0] a16, b16;
    logic        ready16, done16, dbz16, ovf16;
    logic [15:0] q16, r16;

    logic        start8, sgn8;
    logic [7:0]  a8, b8;
    logic        ready8, done8, dbz8, ovf8;
    logic [7:0]  q8, r8;

    int n_cmp = 0;
    int n_err = 0;

    non_restoring_divider #(
        .WIDTH     (16),
        .SIGNED_EN (1'b1)
    ) dut16 (
        .clk         (clk),
        .rst         (rst),
        .start       (start16),
        .is_signed   (sgn16),
        .dividend    (a16),
        .divisor     (b16),
        .ready       (ready16),
        .done        (done16),
        .quotient    (q16),
        .remainder   (r16),
        .div_by_zero (dbz16),
        .overflow    (ovf16)
    );

    non_restoring_divider #(
        .WIDTH     (8),
        .SIGNED_EN (1'b0)
    ) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .is_signed   (sgn8),
        .dividend    (a8),
        .divisor     (b8),
        .ready       (ready8),
        .done        (done8),
        .quotient    (q8),
        .remainder   (r8),
        .div_by_zero (dbz8),
        .overflow    (ovf8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accept edge with operands scrambled.
    task automatic issue16(input logic sg, input logic [15:0] a, input logic [15:0] b);
        start16 = 1'b1;
        sgn16   = sg;
        a16     = a;
        b16     = b;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        a16     = 16'($urandom);
        b16     = 16'($urandom);
    endtask

    task automatic wait_done16(output int lat);
        lat = 0;
        while (!done16 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run16(input string tag, input logic sg, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] eq, input logic [15:0] er,
                         input logic edbz, input logic eovf, input int elat);
        int lat;
        issue16(sg, a, b);
        wait_done16(lat);
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".q"}, q16, eq);
        check({tag, ".r"}, r16, er);
        check({tag, ".dbz"}, dbz16, edbz);
        check({tag, ".ovf"}, ovf16, eovf);
        check({tag, ".ready"}, ready16, 1'b1);
    endtask

    task automatic run8(input string tag, input logic sg, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] eq, input logic [7:0] er,
                        input int elat);
        int lat;
        start8 = 1'b1;
        sgn8   = sg;
        a8     = a;
        b8     = b;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        lat    = 0;
        while (!done8 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".q"}, q8, eq);
        check({tag, ".r"}, r8, er);
        check({tag, ".ovf"}, ovf8, 1'b0);
    endtask

    initial begin
        int lat;
        int seen;

        rst     = 1'b1;
        start16 = 1'b0;
        sgn16   = 1'b0;
        a16     = '0;
        b16     = '0;
        start8  = 1'b0;
        sgn8    = 1'b0;
        a8      = '0;
        b8      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst.ready", ready16, 1'b1);
        check("rst.done", done16, 1'b0);
        check("rst.q", q16, 16'h0000);
        check("rst.r", r16, 16'h0000);
        check("rst.dbz", dbz16, 1'b0);
        check("rst.ovf", ovf16, 1'b0);
        check("rst8.ready", ready8, 1'b1);

        run16("u100_7", 1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17);
        run16("uffff_1", 1'b0, 16'hFFFF, 16'd1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17);
        run16("sm100_7", 1'b1, 16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17);
        run16("s100_m7", 1'b1, 16'd100, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 17);
        run16("sovf", 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 17);
        run16("dbz", 1'b0, 16'd1234, 16'd0, 16'hFFFF, 16'h04D2, 1'b1, 1'b0, 1);

        // Start pulsed mid-iteration must be ignored.
        issue16(1'b0, 16'd1000, 16'd10);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("hs.busy", ready16, 1'b0);
        start16 = 1'b1;
        a16     = 16'd7;
        b16     = 16'd7;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        wait_done16(lat);
        check("hs.lat", 64'(lat + 6), 64'd17);
        check("hs.q", q16, 16'd100);
        check("hs.r", r16, 16'd0);

        // Back-to-back: accept in the done cycle; prior result still visible after accept.
        issue16(1'b0, 16'd50, 16'd5);
        check("b2b.busy", ready16, 1'b0);
        check("b2b.hold_q", q16, 16'd100);
        wait_done16(lat);
        check("b2b.lat", 64'(lat), 64'd17);
        check("b2b.q", q16, 16'd10);
        check("b2b.r", r16, 16'd0);

        // Reset in the middle of an operation.
        issue16(1'b0, 16'd500, 16'd3);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst.ready", ready16, 1'b1);
        check("mrst.done", done16, 1'b0);
        check("mrst.q", q16, 16'd0);
        check("mrst.r", r16, 16'd0);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done16) seen++;
        end
        check("mrst.no_done", 64'(seen), 64'd0);
        run16("u9_2", 1'b0, 16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 1'b0, 17);

        // Unsigned-only instance: is_signed has no effect.
        run8("w8_255_16", 1'b1, 8'd255, 8'd16, 8'd15, 8'd15, 9);
        run8("w8_128_3", 1'b1, 8'h80, 8'd3, 8'd42, 8'd2, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
